// File: rtl/f_le_arbiter.sv
// Round-robin arbiter sharing one combinational f_less_or_equal comparator among NREQ requesters.
// Supports a bounded lock so one requester can issue back-to-back compares.
module f_le_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned MAX_LOCK = 3,
   parameter int unsigned FLEN     = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NREQ-1:0]           req_valid_i,
   input  logic [NREQ-1:0]           req_lock_i,
   input  logic [NREQ-1:0][FLEN-1:0] req_a_i,
   input  logic [NREQ-1:0][FLEN-1:0] req_b_i,
   output logic [NREQ-1:0]           req_ready_o,
   output logic [NREQ-1:0]           rsp_valid_o,
   output logic                      rsp_res_o,
   output logic                      rsp_err_o,
   output logic                      busy_o,
   output logic [FLEN-1:0]           f_le_a_o,
   output logic [FLEN-1:0]           f_le_b_o,
   input  logic                      f_le_res_i,
   input  logic                      f_le_err_i
);

   localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CntW = $clog2(MAX_LOCK + 1);

   logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
   logic            lock_active_q, lock_active_d;
   logic [PtrW-1:0] lock_owner_q, lock_owner_d;
   logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic            rsp_res_q, rsp_res_d;
   logic            rsp_err_q, rsp_err_d;

   logic            grant;
   logic            lock_hit;
   logic [PtrW-1:0] winner;
   int unsigned     cnt_new;

   // Winner selection; no grants are issued while in reset.
   always_comb begin
      grant    = 1'b0;
      winner   = '0;
      lock_hit = lock_active_q & req_valid_i[lock_owner_q];
      if (!rst) begin
         if (lock_hit) begin
            grant  = 1'b1;
            winner = lock_owner_q;
         end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
               if (!grant && req_valid_i[PtrW'((32'(rr_ptr_q) + k) % NREQ)]) begin
                  grant  = 1'b1;
                  winner = PtrW'((32'(rr_ptr_q) + k) % NREQ);
               end
            end
         end
      end
   end

   always_comb begin
      req_ready_o = '0;
      f_le_a_o    = '0;
      f_le_b_o    = '0;
      if (grant) begin
         req_ready_o[winner] = 1'b1;
         f_le_a_o            = req_a_i[winner];
         f_le_b_o            = req_b_i[winner];
      end
   end

   always_comb begin
      rr_ptr_d      = rr_ptr_q;
      lock_active_d = lock_active_q;
      lock_owner_d  = lock_owner_q;
      lock_cnt_d    = lock_cnt_q;
      rsp_valid_d   = req_ready_o;
      rsp_res_d     = rsp_res_q;
      rsp_err_d     = rsp_err_q;
      cnt_new       = 0;

      // Owner dropped its request: release and fall back to round-robin.
      if (lock_active_q && !lock_hit) begin
         lock_active_d = 1'b0;
         lock_cnt_d    = '0;
      end

      if (grant) begin
         rr_ptr_d  = PtrW'((32'(winner) + 32'd1) % NREQ);
         rsp_res_d = f_le_res_i & ~f_le_err_i;
         rsp_err_d = f_le_err_i;
         if (req_lock_i[winner]) begin
            cnt_new = (lock_active_q && (lock_owner_q == winner)) ? 32'(lock_cnt_q) + 32'd1 : 32'd1;
            if (cnt_new < MAX_LOCK) begin
               lock_active_d = 1'b1;
               lock_owner_d  = winner;
               lock_cnt_d    = CntW'(cnt_new);
            end else begin
               lock_active_d = 1'b0;
               lock_cnt_d    = '0;
            end
         end else begin
            lock_active_d = 1'b0;
            lock_cnt_d    = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q      <= '0;
         lock_active_q <= 1'b0;
         lock_owner_q  <= '0;
         lock_cnt_q    <= '0;
         rsp_valid_q   <= '0;
         rsp_res_q     <= 1'b0;
         rsp_err_q     <= 1'b0;
      end else begin
         rr_ptr_q      <= rr_ptr_d;
         lock_active_q <= lock_active_d;
         lock_owner_q  <= lock_owner_d;
         lock_cnt_q    <= lock_cnt_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_res_q     <= rsp_res_d;
         rsp_err_q     <= rsp_err_d;
      end
   end

   // A response in flight when reset arrives is dropped immediately.
   assign rsp_valid_o = rsp_valid_q & {NREQ{~rst}};
   assign rsp_res_o   = rsp_res_q;
   assign rsp_err_o   = rsp_err_q;
   assign busy_o      = lock_active_q;

endmodule

// File: tb/tb_f_le_arbiter.sv
// Table-driven bench for f_le_arbiter with a behavioural double-precision <= comparator.
module tb_f_le_arbiter;

   localparam int unsigned NREQ = 4;
   localparam int unsigned FLEN = 64;

   localparam logic [63:0] ONE = 64'h3FF0000000000000;
   localparam logic [63:0] TWO = 64'h4000000000000000;
   localparam logic [63:0] NAN = 64'h7FF8000000000000;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NREQ-1:0]           req_valid, req_lock;
   logic [NREQ-1:0][FLEN-1:0] req_a, req_b;
   logic [NREQ-1:0]           req_ready, rsp_valid;
   logic                      rsp_res, rsp_err, busy;
   logic [FLEN-1:0]           f_le_a, f_le_b;
   logic                      f_le_res, f_le_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   f_le_arbiter #(.NREQ(NREQ), .MAX_LOCK(3), .FLEN(FLEN)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .req_lock_i  (req_lock),
      .req_a_i     (req_a),
      .req_b_i     (req_b),
      .req_ready_o (req_ready),
      .rsp_valid_o (rsp_valid),
      .rsp_res_o   (rsp_res),
      .rsp_err_o   (rsp_err),
      .busy_o      (busy),
      .f_le_a_o    (f_le_a),
      .f_le_b_o    (f_le_b),
      .f_le_res_i  (f_le_res),
      .f_le_err_i  (f_le_err)
   );

   function automatic logic is_nan(input logic [63:0] x);
      return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
   endfunction

   function automatic logic fle(input logic [63:0] a, input logic [63:0] b);
      if (a[62:0] == 63'd0 && b[62:0] == 63'd0) return 1'b1;
      if (a[63] != b[63]) return a[63];
      if (!a[63]) return a[62:0] <= b[62:0];
      return a[62:0] >= b[62:0];
   endfunction

   always_comb begin
      f_le_err = is_nan(f_le_a) | is_nan(f_le_b);
      f_le_res = fle(f_le_a, f_le_b);
   end

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [3:0]  lock;
      logic [63:0] a;
      logic [63:0] b;
      logic [3:0]  ready;  // grant this cycle
      logic [3:0]  rsp;    // response from previous cycle's grant
      logic        res;
      logic        err;
      logic        busy;
   } vec_t;

   function automatic vec_t v(input logic r, input logic [3:0] vl, input logic [3:0] lk,
                              input logic [63:0] a, input logic [63:0] b, input logic [3:0] rdy,
                              input logic [3:0] rsp, input logic res, input logic err,
                              input logic bsy);
      vec_t t;
      t.rst = r; t.valid = vl; t.lock = lk; t.a = a; t.b = b;
      t.ready = rdy; t.rsp = rsp; t.res = res; t.err = err; t.busy = bsy;
      return t;
   endfunction

   task automatic chk(input string name, input int idx, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   vec_t tv[28];

   initial begin
      // reset state
      tv[0]  = v(0, 4'b0000, 4'b0000, ONE, TWO, 4'b0000, 4'b0000, 0, 0, 0);
      // single request 1.0 <= 2.0
      tv[1]  = v(0, 4'b0001, 4'b0000, ONE, TWO, 4'b0001, 4'b0000, 0, 0, 0);
      tv[2]  = v(0, 4'b0000, 4'b0000, ONE, TWO, 4'b0000, 4'b0001, 1, 0, 0);
      // reset, then full round-robin
      tv[3]  = v(1, 4'b0000, 4'b0000, ONE, TWO, 4'b0000, 4'b0000, 1, 0, 0);
      tv[4]  = v(0, 4'b1111, 4'b0000, ONE, TWO, 4'b0001, 4'b0000, 0, 0, 0);
      tv[5]  = v(0, 4'b1111, 4'b0000, ONE, TWO, 4'b0010, 4'b0001, 1, 0, 0);
      tv[6]  = v(0, 4'b1111, 4'b0000, ONE, TWO, 4'b0100, 4'b0010, 1, 0, 0);
      tv[7]  = v(0, 4'b1111, 4'b0000, ONE, TWO, 4'b1000, 4'b0100, 1, 0, 0);
      tv[8]  = v(0, 4'b1111, 4'b0000, ONE, TWO, 4'b0001, 4'b1000, 1, 0, 0);
      // NaN error, then 1.0 vs 1.0, then hold with no grant
      tv[9]  = v(0, 4'b0100, 4'b0000, NAN, ONE, 4'b0100, 4'b0001, 1, 0, 0);
      tv[10] = v(0, 4'b1000, 4'b0000, ONE, ONE, 4'b1000, 4'b0100, 0, 1, 0);
      tv[11] = v(0, 4'b0000, 4'b0000, ONE, TWO, 4'b0000, 4'b1000, 1, 0, 0);
      tv[12] = v(0, 4'b0000, 4'b0000, ONE, TWO, 4'b0000, 4'b0000, 1, 0, 0);
      // bounded lock: 1,1,1 forced release, then 2,0,1
      tv[13] = v(0, 4'b0010, 4'b0010, ONE, TWO, 4'b0010, 4'b0000, 1, 0, 0);
      tv[14] = v(0, 4'b0111, 4'b0010, ONE, TWO, 4'b0010, 4'b0010, 1, 0, 1);
      tv[15] = v(0, 4'b0111, 4'b0010, ONE, TWO, 4'b0010, 4'b0010, 1, 0, 1);
      tv[16] = v(0, 4'b0111, 4'b0010, ONE, TWO, 4'b0100, 4'b0010, 1, 0, 0);
      tv[17] = v(0, 4'b0111, 4'b0010, ONE, TWO, 4'b0001, 4'b0100, 1, 0, 0);
      tv[18] = v(0, 4'b0111, 4'b0010, ONE, TWO, 4'b0010, 4'b0001, 1, 0, 0);
      // lock drop: owner 1 drops, 3 locks, then 3 drops and 0 wins after wrap
      tv[19] = v(0, 4'b1000, 4'b1000, ONE, TWO, 4'b1000, 4'b0010, 1, 0, 1);
      tv[20] = v(0, 4'b0011, 4'b0000, ONE, TWO, 4'b0001, 4'b1000, 1, 0, 1);
      tv[21] = v(0, 4'b0000, 4'b0000, ONE, TWO, 4'b0000, 4'b0001, 1, 0, 0);
      // reset mid-operation drops the in-flight response
      tv[22] = v(0, 4'b0010, 4'b0000, ONE, TWO, 4'b0010, 4'b0000, 1, 0, 0);
      tv[23] = v(1, 4'b0000, 4'b0000, ONE, TWO, 4'b0000, 4'b0000, 1, 0, 0);
      tv[24] = v(0, 4'b0011, 4'b0000, ONE, TWO, 4'b0001, 4'b0000, 0, 0, 0);
      tv[25] = v(0, 4'b0000, 4'b0000, ONE, TWO, 4'b0000, 4'b0001, 1, 0, 0);
      // 2.0 <= 1.0 is false without error
      tv[26] = v(0, 4'b0001, 4'b0000, TWO, ONE, 4'b0001, 4'b0000, 1, 0, 0);
      tv[27] = v(0, 4'b0000, 4'b0000, TWO, ONE, 4'b0000, 4'b0001, 0, 0, 0);

      rst       = 1'b1;
      req_valid = '0;
      req_lock  = '0;
      req_a     = '0;
      req_b     = '0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 28; i++) begin
         logic [63:0] exp_a, exp_b;
         @(negedge clk);
         rst       = tv[i].rst;
         req_valid = tv[i].valid;
         req_lock  = tv[i].lock;
         // Tag each requester's operands so the operand mux can be checked.
         for (int r = 0; r < NREQ; r++) begin
            req_a[r] = tv[i].a | (64'(r) << 4);
            req_b[r] = tv[i].b | (64'(r) << 4);
         end
         exp_a = '0;
         exp_b = '0;
         for (int r = 0; r < NREQ; r++) begin
            if (tv[i].ready[r]) begin
               exp_a = tv[i].a | (64'(r) << 4);
               exp_b = tv[i].b | (64'(r) << 4);
            end
         end
         #1;
         chk("req_ready", i, 64'(req_ready), 64'(tv[i].ready));
         chk("f_le_a",    i, f_le_a,          exp_a);
         chk("f_le_b",    i, f_le_b,          exp_b);
         chk("rsp_valid", i, 64'(rsp_valid), 64'(tv[i].rsp));
         chk("rsp_res",   i, 64'(rsp_res),   64'(tv[i].res));
         chk("rsp_err",   i, 64'(rsp_err),   64'(tv[i].err));
         chk("busy",      i, 64'(busy),      64'(tv[i].busy));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/f_le_arbiter.md
Name: f_le_arbiter

Overview:
- Round-robin arbiter that shares the single combinational f_less_or_equal comparator among NREQ requesters, such as sort FSMs and min/max units.
- Each cycle it grants one requester and steers that requester's operands to the comparator.
- The result is registered and returned to the winner one cycle later.
- An optional lock lets a requester hold the comparator for back-to-back comparisons, for example a 3-compare sort. The lock is bounded by MAX_LOCK so no requester starves.

Parameters:
NREQ, 4, number of requesters (2..8)
MAX_LOCK, 3, maximum consecutive locked grants to one requester before forced release (>=1)
FLEN, from config-shared.vh (64), operand width; global, not overridden per instance

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  NREQ  requester i has a comparison pending
req_lock  in  NREQ  requester i asks to keep the grant after this one
req_a  in  NREQ x FLEN  operand a of requester i
req_b  in  NREQ x FLEN  operand b of requester i
req_ready  out  NREQ  one-hot grant; the request is accepted when req_valid[i] & req_ready[i]
rsp_valid  out  NREQ  one-hot; result for requester i is valid this cycle
rsp_res  out  1  registered f_le_res (a <= b)
rsp_err  out  1  registered f_le_err
busy  out  1  lock currently held
f_le_a  out  FLEN  comparator operand a
f_le_b  out  FLEN  comparator operand b
f_le_res  in  1  comparator result, combinational from f_le_a/f_le_b
f_le_err  in  1  comparator error (NaN operand)

Behaviour:
- Reset: rst is synchronous and active-high, clock is clk. Reset sets rr_ptr=0, lock_active=0, lock_owner=0, lock_cnt=0, rsp_valid=0, rsp_res=0, rsp_err=0.
- Grant selection (combinational, same cycle):
  - If lock_active and req_valid[lock_owner], then winner = lock_owner.
  - Otherwise winner = first i with req_valid[i], searching from rr_ptr upward with wrap mod NREQ.
  - If no req_valid is set, there is no grant.
- Grant outputs:
  - req_ready is asserted only for the winner and is never asserted without the matching req_valid.
  - f_le_a = req_a[winner] and f_le_b = req_b[winner].
  - With no grant, f_le_a = 0 and f_le_b = 0.
- Response (1-cycle latency, registered):
  - Next cycle, rsp_valid[winner] = 1, rsp_res = f_le_res & ~f_le_err, rsp_err = f_le_err.
  - Cycles without a grant give rsp_valid = 0, and rsp_res/rsp_err hold their previous values.
- No backpressure on responses: the requester must consume the result in the cycle rsp_valid is high.
- Full throughput: one grant per cycle. A requester may keep req_valid high across consecutive cycles and is granted again per the arbitration rules.
- rr_ptr update: on every grant, rr_ptr <= (winner+1) mod NREQ, locked grants included. Unchanged when there is no grant.
- Lock state machine (lock_active, lock_owner, lock_cnt):
  - Grant to g with req_lock[g]=1:
    - cnt_new = (lock_active & lock_owner==g) ? lock_cnt+1 : 1.
    - If cnt_new < MAX_LOCK: lock_active<=1, lock_owner<=g, lock_cnt<=cnt_new.
    - Otherwise lock_active<=0 and lock_cnt<=0 (forced release).
  - Grant to g with req_lock[g]=0: lock_active<=0, lock_cnt<=0.
  - lock_active while req_valid[lock_owner]=0: the lock is released (lock_active<=0, lock_cnt<=0) and normal round-robin arbitration applies in that same cycle.
  - MAX_LOCK=1 means a lock never persists.
- Errors: f_le_err affects only rsp_err. Arbitration, lock and rr_ptr are unaffected.
- busy = lock_active.
- Reset mid-operation: an in-flight response is dropped, so rsp_valid=0 in the cycle after rst. The lock is cleared.
- Simultaneous requests: exactly one grant per cycle. Losers keep req_valid high and are served in round-robin order.

Test Plan:
1. Single request, reset then req_valid[0]=1, a=0x3FF0000000000000 (1.0), b=0x4000000000000000 (2.0) at cycle T -> req_ready[0]=1 at T; at T+1 rsp_valid=0001, rsp_res=1, rsp_err=0.
2. Round-robin, req_valid=1111 held for 5 cycles, no lock -> req_ready sequence 0001, 0010, 0100, 1000, 0001; rsp_valid is the same sequence delayed 1 cycle.
3. Error case, requester 2 with a=0x7FF8000000000000 (NaN), b=1.0 -> one cycle later rsp_valid=0100, rsp_err=1, rsp_res=0. Next request 1.0 vs 1.0 from requester 3 -> rsp_res=1, rsp_err=0.
4. Bounded lock, MAX_LOCK=3:
   - Cycle 0: req_valid=0010 with req_lock[1]=1.
   - Cycles 1+: req_valid=0111, req_lock[1] held high.
   - Expected grants: 1, 1, 1 (forced release), then 2, 0, 1.
   - busy is high after the first and second grants and low after the third.
5. Lock drop: requester 3 is locked (busy=1), then deasserts req_valid while req 0 and req 1 are valid -> same cycle grant goes to req 0 (rr_ptr=0 after wrap); busy=0 next cycle.
6. Reset mid-operation, grant to requester 1 at T and rst=1 at T+1 -> rsp_valid=0 at T+1 and T+2, busy=0. First grant after reset goes to requester 0 when req_valid=0011.
